// File: rtl/ysyx_25020047_seq.sv
// Multi-cycle instruction sequencer: owns PC/IR and steps fetch, execute, memory
// and writeback over a shared valid/ready memory port with fault and timeout detection.
module ysyx_25020047_seq #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h8000_0000),
  parameter int unsigned          TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err,
  output logic [ADDR_W-1:0]   pc,
  output logic [31:0]         inst,
  input  logic [ADDR_W-1:0]   ex_dnpc,
  input  logic                ex_is_load,
  input  logic                ex_is_store,
  input  logic                ex_trap,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W/8-1:0] ex_wmask,
  output logic [DATA_W-1:0]   load_data,
  output logic                commit,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_cause
);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_IF_REQ   = 4'd1;
  localparam logic [3:0] S_IF_WAIT  = 4'd2;
  localparam logic [3:0] S_EX       = 4'd3;
  localparam logic [3:0] S_MEM_REQ  = 4'd4;
  localparam logic [3:0] S_MEM_WAIT = 4'd5;
  localparam logic [3:0] S_WB       = 4'd6;
  localparam logic [3:0] S_HALT     = 4'd7;
  localparam logic [3:0] S_FAULT    = 4'd8;

  logic [3:0]          r_state, w_next;
  logic [1:0]          w_cause;
  logic [ADDR_W-1:0]   r_pc, r_dnpc, r_addr;
  logic [31:0]         r_inst;
  logic [DATA_W-1:0]   r_ld, r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic                r_wen, r_trap, r_halted, r_fault;
  logic [1:0]          r_cause;
  logic [31:0]         r_cnt;
  logic                w_misal, w_to, w_st;

  assign w_misal = r_pc[1:0] != 2'b00;
  // Expires on the TIMEOUT-th wait cycle; a response in that same cycle still wins.
  assign w_to    = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

  always_comb begin
    w_next  = r_state;
    w_cause = 2'd0;
    case (r_state)
      S_IDLE:     w_next = S_IF_REQ;
      S_IF_REQ: begin
        if (w_misal) begin
          w_next  = S_FAULT;
          w_cause = 2'd1;
        end else if (mem_req_ready) w_next = S_IF_WAIT;
      end
      S_IF_WAIT, S_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            w_next  = S_FAULT;
            w_cause = 2'd2;
          end else w_next = (r_state == S_IF_WAIT) ? S_EX : S_WB;
        end else if (w_to) begin
          w_next  = S_FAULT;
          w_cause = 2'd3;
        end
      end
      S_EX:       w_next = (ex_is_load || ex_is_store) ? S_MEM_REQ : S_WB;
      S_MEM_REQ:  if (mem_req_ready) w_next = S_MEM_WAIT;
      S_WB:       w_next = r_trap ? S_HALT : S_IF_REQ;
      S_HALT:     w_next = S_HALT;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_inst   <= '0;
      r_ld     <= '0;
      r_dnpc   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_wen    <= 1'b0;
      r_trap   <= 1'b0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_cause  <= 2'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IF_REQ, S_MEM_REQ:   r_cnt <= '0;
        S_IF_WAIT, S_MEM_WAIT: r_cnt <= r_cnt + 32'd1;
        default: ;
      endcase
      if (r_state == S_IF_WAIT && mem_rsp_valid && !mem_rsp_err) r_inst <= mem_rsp_data[31:0];
      if (r_state == S_MEM_WAIT && mem_rsp_valid && !mem_rsp_err && !r_wen) r_ld <= mem_rsp_data;
      if (r_state == S_EX) begin
        r_dnpc  <= ex_dnpc;
        r_trap  <= ex_trap;
        r_addr  <= ex_addr;
        r_wdata <= ex_wdata;
        r_wmask <= ex_wmask;
        r_wen   <= ex_is_store;
      end
      if (r_state == S_WB) r_pc <= r_dnpc;
      if (w_next == S_HALT) r_halted <= 1'b1;
      if (w_next == S_FAULT && r_state != S_FAULT) begin
        r_fault <= 1'b1;
        r_cause <= w_cause;
      end
    end
  end

  // Request fields derive from state and latched operands only, so they hold until ready.
  assign w_st          = (r_state == S_MEM_REQ) && r_wen;
  assign mem_req_valid = (r_state == S_IF_REQ && !w_misal) || (r_state == S_MEM_REQ);
  assign mem_req_addr  = (r_state == S_IF_REQ)  ? r_pc :
                         (r_state == S_MEM_REQ) ? r_addr : '0;
  assign mem_req_wen   = w_st;
  assign mem_req_wdata = w_st ? r_wdata : '0;
  assign mem_req_wmask = w_st ? r_wmask : '0;

  assign pc          = r_pc;
  assign inst        = r_inst;
  assign load_data   = r_ld;
  assign commit      = (r_state == S_WB);
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
endmodule

// File: tb/tb_ysyx_25020047_seq.sv
// Scoreboard bench: a memory responder serves scripted transactions, a monitor
// pops expected requests/commits whenever the sequencer presents them.
module tb_ysyx_25020047_seq;
  logic        clk = 0;
  logic        rst = 1;
  logic        mem_req_valid, mem_req_ready = 0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 0;
  logic [31:0] mem_rsp_data = 0;
  logic        mem_rsp_err = 0;
  logic [31:0] pc, inst, load_data;
  logic [31:0] ex_dnpc = 0, ex_addr = 0, ex_wdata = 0;
  logic        ex_is_load = 0, ex_is_store = 0, ex_trap = 0;
  logic [3:0]  ex_wmask = 0;
  logic        commit, halted, fault;
  logic [1:0]  fault_cause;

  ysyx_25020047_seq #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .pc(pc), .inst(inst), .ex_dnpc(ex_dnpc), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_trap(ex_trap), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_wmask(ex_wmask), .load_data(load_data),
    .commit(commit), .halted(halted), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } req_t;
  typedef struct packed { logic [31:0] cyc; logic [31:0] inst; logic [31:0] ld; } cmt_t;
  typedef struct { int rdy_wait; int rsp_wait; logic [31:0] data; logic err; logic none; } desc_t;

  req_t  exp_req[$];
  cmt_t  exp_cmt[$];
  desc_t desc_q[$];
  int    n_vec = 0, n_err = 0;
  int    stale_cyc = -1;
  logic [31:0] cyc = 0;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory responder: acts #1 after each rising edge.
  initial begin
    desc_t cur;
    int rdy_cnt, rsp_cnt;
    bit busy, waiting;
    busy = 0; waiting = 0; rdy_cnt = 0; rsp_cnt = 0;
    cur = '{0, 0, 32'h0, 1'b0, 1'b0};
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_data = 0;
      if (!rst) begin
        busy = 0; waiting = 0;
      end else begin
        if (int'(cyc) == stale_cyc) begin
          mem_rsp_valid = 1; mem_rsp_data = 32'hBADBAD00;
        end
        if (waiting) begin
          if (!cur.none) begin
            if (rsp_cnt == 0) begin
              mem_rsp_valid = 1; mem_rsp_data = cur.data; mem_rsp_err = cur.err; waiting = 0;
            end else rsp_cnt--;
          end
        end else if (mem_req_valid) begin
          if (!busy && desc_q.size() > 0) begin
            cur = desc_q.pop_front(); busy = 1; rdy_cnt = cur.rdy_wait;
          end
          if (busy) begin
            if (rdy_cnt == 0) begin
              mem_req_ready = 1; busy = 0; waiting = 1; rsp_cnt = cur.rsp_wait;
            end else rdy_cnt--;
          end
        end
      end
    end
  end

  // Monitor: samples mid-cycle, values that the next rising edge will see.
  initial begin
    req_t prev, now;
    bit   prev_stall;
    prev = '0; prev_stall = 0;
    forever begin
      @(negedge clk);
      now = '{mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask};
      if (!rst) prev_stall = 0;
      else begin
        if (prev_stall) begin
          chk("req_held_valid", 128'(mem_req_valid), 128'(1'b1));
          chk("req_held_fields", 128'(now), 128'(prev));
        end
        if (mem_req_valid && mem_req_ready) begin
          if (exp_req.size() == 0) chk("req_unexpected", 128'(now), 128'(0));
          else chk("req", 128'(now), 128'(exp_req.pop_front()));
        end
        if (commit) begin
          if (exp_cmt.size() == 0) chk("commit_unexpected", 128'(cyc), 128'(0));
          else chk("commit", 128'({cyc, inst, load_data}), 128'(exp_cmt.pop_front()));
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev = now;
      end
    end
  end

  // Returns at #2 after the rising edge that starts cycle c.
  task automatic at_cyc(input int c);
    int n = 0;
    while (int'(cyc) < c && n < 300) begin @(posedge clk); #2; n++; end
    if (int'(cyc) != c) begin
      n_vec++; n_err++;
      $display("FAIL wait_cycle actual=%0d expected=%0d", cyc, c);
    end
  endtask

  task automatic do_reset();
    chk("queues_drained", 128'(exp_req.size() + exp_cmt.size()), 128'(0));
    #1 rst = 0;
    desc_q.delete(); exp_req.delete(); exp_cmt.delete(); stale_cyc = -1;
    ex_dnpc = 32'h8000_0004; ex_is_load = 0; ex_is_store = 0; ex_trap = 0;
    ex_addr = 0; ex_wdata = 0; ex_wmask = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  function automatic req_t fetch(input logic [31:0] a);
    return '{a, 1'b0, 32'h0, 4'h0};
  endfunction

  initial begin
    #1 rst = 0;
    repeat (2) @(posedge clk); #2;
    chk("rst_pc", 128'(pc), 128'(32'h8000_0000));
    chk("rst_inst", 128'(inst), 128'(0));
    chk("rst_load_data", 128'(load_data), 128'(0));
    chk("rst_cause", 128'(fault_cause), 128'(0));
    chk("rst_ctrl", 128'({mem_req_valid, mem_req_wen, mem_req_wmask, commit, halted, fault}), 128'(0));
    chk("rst_addr_wdata", 128'({mem_req_addr, mem_req_wdata}), 128'(0));
    ex_dnpc = 32'h8000_0004;
    @(posedge clk); #1 rst = 1;

    // ALU instruction, zero wait
    desc_q.push_back('{0, 0, 32'h0010_0093, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_cmt.push_back('{32'd4, 32'h0010_0093, 32'h0});
    at_cyc(5);
    chk("addi_pc", 128'(pc), 128'(32'h8000_0004));
    do_reset();

    // Load with 3 response wait cycles
    ex_is_load = 1; ex_addr = 32'h8000_1000;
    desc_q.push_back('{0, 0, 32'h0000_2083, 1'b0, 1'b0});
    desc_q.push_back('{0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_req.push_back('{32'h8000_1000, 1'b0, 32'h0, 4'h0});
    exp_cmt.push_back('{32'd9, 32'h0000_2083, 32'hDEAD_BEEF});
    at_cyc(10);
    chk("load_pc", 128'(pc), 128'(32'h8000_0004));
    do_reset();

    // Store, ready held low for 5 cycles
    ex_is_store = 1; ex_addr = 32'h8000_2004; ex_wdata = 32'h1234_5678; ex_wmask = 4'b0011;
    desc_q.push_back('{0, 0, 32'h0011_2223, 1'b0, 1'b0});
    desc_q.push_back('{5, 0, 32'hFFFF_FFFF, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_req.push_back('{32'h8000_2004, 1'b1, 32'h1234_5678, 4'b0011});
    exp_cmt.push_back('{32'd11, 32'h0011_2223, 32'h0});
    at_cyc(6);
    chk("store_stall_valid", 128'({mem_req_valid, mem_req_ready}), 128'(2'b10));
    at_cyc(12);
    do_reset();

    // ebreak: halt, no more requests
    ex_trap = 1;
    desc_q.push_back('{0, 0, 32'h0010_0073, 1'b0, 1'b0});
    desc_q.push_back('{0, 0, 32'h0, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_cmt.push_back('{32'd4, 32'h0010_0073, 32'h0});
    at_cyc(4);
    chk("halt_before", 128'(halted), 128'(0));
    for (int i = 0; i < 20; i++) begin
      at_cyc(5 + i);
      chk("halt_quiet", 128'({halted, mem_req_valid}), 128'(2'b10));
    end
    chk("halt_pc", 128'(pc), 128'(32'h8000_0004));
    do_reset();

    // Misaligned next PC
    ex_dnpc = 32'h8000_0002;
    desc_q.push_back('{0, 0, 32'h0000_0013, 1'b0, 1'b0});
    desc_q.push_back('{0, 0, 32'h0000_0013, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_cmt.push_back('{32'd4, 32'h0000_0013, 32'h0});
    at_cyc(5);
    chk("misal_noreq", 128'({mem_req_valid, fault}), 128'(0));
    at_cyc(6);
    chk("misal_fault", 128'({fault, fault_cause}), 128'(3'b101));
    at_cyc(9);
    chk("misal_sticky", 128'({fault, fault_cause, mem_req_valid}), 128'(4'b1010));
    do_reset();

    // Bus error on fetch
    desc_q.push_back('{0, 0, 32'h0000_0013, 1'b1, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    at_cyc(2);
    chk("err_before", 128'(fault), 128'(0));
    at_cyc(3);
    chk("err_fault", 128'({fault, fault_cause}), 128'(3'b110));
    do_reset();

    // No response: timeout after 8 wait cycles
    desc_q.push_back('{0, 0, 32'h0, 1'b0, 1'b1});
    exp_req.push_back(fetch(32'h8000_0000));
    at_cyc(9);
    chk("to_before", 128'(fault), 128'(0));
    at_cyc(10);
    chk("to_fault", 128'({fault, fault_cause}), 128'(3'b111));
    do_reset();

    // Response lands in the 8th wait cycle: response beats timeout
    desc_q.push_back('{0, 7, 32'h0000_0013, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_cmt.push_back('{32'd11, 32'h0000_0013, 32'h0});
    at_cyc(12);
    chk("to_race_nofault", 128'(fault), 128'(0));
    do_reset();

    // Reset during MEM_WAIT, stale response after release
    ex_is_load = 1; ex_addr = 32'h8000_3000;
    desc_q.push_back('{0, 0, 32'h0000_2083, 1'b0, 1'b0});
    desc_q.push_back('{0, 0, 32'h0, 1'b0, 1'b1});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_req.push_back('{32'h8000_3000, 1'b0, 32'h0, 4'h0});
    at_cyc(6);
    #1 rst = 0;
    #1 chk("midrst_state", 128'({pc, mem_req_valid, commit}), 128'({32'h8000_0000, 2'b00}));
    desc_q.delete();
    ex_is_load = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    stale_cyc = 2;
    desc_q.push_back('{3, 0, 32'h0000_0013, 1'b0, 1'b0});
    exp_req.push_back(fetch(32'h8000_0000));
    exp_cmt.push_back('{32'd7, 32'h0000_0013, 32'h0});
    at_cyc(8);
    chk("stale_pc", 128'({pc, fault}), 128'({32'h8000_0004, 1'b0}));
    chk("queues_drained", 128'(exp_req.size() + exp_cmt.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
